// File: rtl/palindrome_dispatch.sv
// palindrome_dispatch
// Job dispatcher in front of the palindrome checker. (base, ending) jobs are
// queued in a small FIFO. Each job is issued to the checker over a go/done
// handshake. Exactly one result per job comes back over a valid/ready port,
// and results leave in push order. A degenerate range (base >= ending) is
// answered locally as a palindrome and never engages the checker. A checker
// that does not answer within TIMEOUT cycles has its job aborted, and the
// job is reported with res_timeout=1.
//
// Ports
//   clock          rising-edge clock
//   reset          asynchronous active-low reset
//   req_valid/req_ready/req_base/req_ending   job input (valid/ready)
//   chk_base/chk_ending/chk_go                registered checker request
//   chk_done/chk_palindrome                   checker response
//   res_valid/res_ready/res_palindrome/res_timeout/res_base/res_ending
//                                             result output (valid/ready)
//   job_count      jobs waiting in the FIFO (excludes the job in flight)
module palindrome_dispatch #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64,
  parameter int CW      = 3
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [4:0]    req_base,
  input  logic [4:0]    req_ending,
  output logic [4:0]    chk_base,
  output logic [4:0]    chk_ending,
  output logic          chk_go,
  input  logic          chk_done,
  input  logic          chk_palindrome,
  output logic          res_valid,
  input  logic          res_ready,
  output logic          res_palindrome,
  output logic          res_timeout,
  output logic [4:0]    res_base,
  output logic [4:0]    res_ending,
  output logic [CW-1:0] job_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    REPORT = 2'd2
  } state_t;

  state_t        state_r, state_nxt_s;
  logic [4:0]    mem_base_r [DEPTH];
  logic [4:0]    mem_end_r  [DEPTH];
  logic [AW-1:0] wr_ptr_r, rd_ptr_r;
  logic [CW-1:0] count_r, count_nxt_s;
  logic [TW-1:0] timer_r, timer_nxt_s;

  logic          chk_go_r, chk_go_nxt_s;
  logic [4:0]    chk_base_r, chk_base_nxt_s;
  logic [4:0]    chk_end_r, chk_end_nxt_s;
  logic          res_valid_r, res_valid_nxt_s;
  logic          res_pal_r, res_pal_nxt_s;
  logic          res_to_r, res_to_nxt_s;
  logic [4:0]    res_base_r, res_base_nxt_s;
  logic [4:0]    res_end_r, res_end_nxt_s;

  logic          push_s, pop_s, ready_s, empty_s;
  logic [4:0]    head_base_s, head_end_s;

  assign ready_s     = (count_r < CW'(DEPTH));
  assign empty_s     = (count_r == {CW{1'b0}});
  assign push_s      = req_valid & ready_s;
  assign head_base_s = mem_base_r[rd_ptr_r];
  assign head_end_s  = mem_end_r[rd_ptr_r];

  assign req_ready      = ready_s;
  assign job_count      = count_r;
  assign chk_go         = chk_go_r;
  assign chk_base       = chk_base_r;
  assign chk_ending     = chk_end_r;
  assign res_valid      = res_valid_r;
  assign res_palindrome = res_pal_r;
  assign res_timeout    = res_to_r;
  assign res_base       = res_base_r;
  assign res_ending     = res_end_r;

  // FIFO storage; contents need no reset because the count gates every read.
  always_ff @(posedge clock) begin
    if (push_s) begin
      mem_base_r[wr_ptr_r] <= req_base;
      mem_end_r[wr_ptr_r]  <= req_ending;
    end
  end

  // FIFO occupancy: a simultaneous push and pop leaves the count unchanged.
  always_comb begin
    count_nxt_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + {{(CW-1){1'b0}}, 1'b1};
      2'b01:   count_nxt_s = count_r - {{(CW-1){1'b0}}, 1'b1};
      default: count_nxt_s = count_r;
    endcase
  end

  // FIFO pointers and count; the pointers wrap naturally because DEPTH is a power of 2.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + {{(AW-1){1'b0}}, 1'b1};
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + {{(AW-1){1'b0}}, 1'b1};
      end
      count_r <= count_nxt_s;
    end
  end

  // Next-state and next-output logic of the dispatcher FSM.
  always_comb begin
    state_nxt_s     = state_r;
    timer_nxt_s     = timer_r;
    chk_go_nxt_s    = chk_go_r;
    chk_base_nxt_s  = chk_base_r;
    chk_end_nxt_s   = chk_end_r;
    res_valid_nxt_s = res_valid_r;
    res_pal_nxt_s   = res_pal_r;
    res_to_nxt_s    = res_to_r;
    res_base_nxt_s  = res_base_r;
    res_end_nxt_s   = res_end_r;
    pop_s           = 1'b0;
    case (state_r)
      IDLE: begin
        if (!empty_s) begin
          pop_s          = 1'b1;
          res_base_nxt_s = head_base_s;
          res_end_nxt_s  = head_end_s;
          if (head_base_s >= head_end_s) begin
            // Empty or single-register range: trivially a palindrome.
            res_pal_nxt_s   = 1'b1;
            res_to_nxt_s    = 1'b0;
            res_valid_nxt_s = 1'b1;
            state_nxt_s     = REPORT;
          end else begin
            chk_base_nxt_s = head_base_s;
            chk_end_nxt_s  = head_end_s;
            chk_go_nxt_s   = 1'b1;
            timer_nxt_s    = {TW{1'b0}};
            state_nxt_s    = RUN;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RUN: begin
        // A done in the expiry cycle still counts as an answer.
        if (chk_done) begin
          res_pal_nxt_s   = chk_palindrome;
          res_to_nxt_s    = 1'b0;
          chk_go_nxt_s    = 1'b0;
          res_valid_nxt_s = 1'b1;
          state_nxt_s     = REPORT;
        end else if (timer_r == TW'(TIMEOUT - 1)) begin
          res_pal_nxt_s   = 1'b0;
          res_to_nxt_s    = 1'b1;
          chk_go_nxt_s    = 1'b0;
          res_valid_nxt_s = 1'b1;
          state_nxt_s     = REPORT;
        end else begin
          timer_nxt_s = timer_r + {{(TW-1){1'b0}}, 1'b1};
        end
      end
      REPORT: begin
        // Lasting at least one cycle keeps chk_go low between jobs.
        chk_go_nxt_s = 1'b0;
        if (res_ready) begin
          res_valid_nxt_s = 1'b0;
          state_nxt_s     = IDLE;
        end else begin
          state_nxt_s = REPORT;
        end
      end
      default: begin
        state_nxt_s     = IDLE;
        chk_go_nxt_s    = 1'b0;
        res_valid_nxt_s = 1'b0;
      end
    endcase
  end

  // State register and the registered checker/result outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r     <= IDLE;
      timer_r     <= {TW{1'b0}};
      chk_go_r    <= 1'b0;
      chk_base_r  <= 5'd0;
      chk_end_r   <= 5'd0;
      res_valid_r <= 1'b0;
      res_pal_r   <= 1'b0;
      res_to_r    <= 1'b0;
      res_base_r  <= 5'd0;
      res_end_r   <= 5'd0;
    end else begin
      state_r     <= state_nxt_s;
      timer_r     <= timer_nxt_s;
      chk_go_r    <= chk_go_nxt_s;
      chk_base_r  <= chk_base_nxt_s;
      chk_end_r   <= chk_end_nxt_s;
      res_valid_r <= res_valid_nxt_s;
      res_pal_r   <= res_pal_nxt_s;
      res_to_r    <= res_to_nxt_s;
      res_base_r  <= res_base_nxt_s;
      res_end_r   <= res_end_nxt_s;
    end
  end

endmodule

// File: tb/tb_palindrome_dispatch.sv
// Self-checking bench for palindrome_dispatch: a behavioural checker model
// answers go requests, and a job-queue reference model predicts every
// result, the queue occupancy and the checker request contents.
module tb_palindrome_dispatch;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 64;
  localparam int CW      = 3;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          req_valid = 1'b0, req_ready;
  logic [4:0]    req_base = 5'd0, req_ending = 5'd0;
  logic [4:0]    chk_base, chk_ending;
  logic          chk_go;
  logic          chk_done = 1'b0, chk_palindrome = 1'b0;
  logic          res_valid, res_ready = 1'b0;
  logic          res_palindrome, res_timeout;
  logic [4:0]    res_base, res_ending;
  logic [CW-1:0] job_count;

  palindrome_dispatch #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .CW(CW)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_base(req_base), .req_ending(req_ending),
    .chk_base(chk_base), .chk_ending(chk_ending), .chk_go(chk_go),
    .chk_done(chk_done), .chk_palindrome(chk_palindrome),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_palindrome(res_palindrome), .res_timeout(res_timeout),
    .res_base(res_base), .res_ending(res_ending),
    .job_count(job_count)
  );

  always #5 clock = ~clock;

  typedef struct { logic [4:0] b; logic [4:0] e; } job_t;
  typedef struct { int d; bit pal; } plan_t;

  job_t  exp_q[$];     // pushed jobs not yet reported, in push order
  plan_t force_q[$];   // directed checker answers, used before random ones
  int    checks = 0, errors = 0;
  int    exp_count = 0, go_cycles = 0, go_rises = 0, results_seen = 0;
  int    plan_d = 1;   // done arrives in the plan_d-th cycle of go (never if > TIMEOUT)
  bit    plan_pal = 1'b0;
  bit    inject_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Checker model: answers each go after plan_d cycles; may emit stray dones while idle.
  initial begin
    int    run_k;
    plan_t p;
    int    r;
    run_k = 0;
    forever begin
      @(posedge clock); #1;
      if (chk_go) begin
        run_k++;
        if (run_k == 1) begin
          if (force_q.size() > 0) begin
            p = force_q.pop_front();
          end else begin
            r = $urandom_range(0, 9);
            p.d   = (r == 0) ? TIMEOUT + 10 : (r == 1) ? TIMEOUT : $urandom_range(1, 8);
            p.pal = 1'($urandom_range(0, 1));
          end
          plan_d   = p.d;
          plan_pal = p.pal;
        end
        chk_done       = (run_k == plan_d);
        chk_palindrome = (run_k == plan_d) ? plan_pal : 1'($urandom_range(0, 1));
      end else begin
        run_k          = 0;
        chk_done       = inject_en && ($urandom_range(0, 3) == 0);
        chk_palindrome = 1'($urandom_range(0, 1));
      end
    end
  end

  // Compare process: reference model of queue/results, checked every cycle.
  initial begin
    logic prev_go, prev_rv;
    bit   triv;
    int   exp_gc;
    prev_go = 1'b0;
    prev_rv = 1'b0;
    forever begin
      @(negedge clock);
      if (!reset) begin
        exp_q.delete();
        exp_count = 0;
        prev_go   = 1'b0;
        prev_rv   = 1'b0;
      end else begin
        // A job leaves the queue when go rises or a local answer appears.
        if (chk_go && !prev_go) begin
          go_rises++;
          go_cycles = 0;
          if (exp_q.size() == 0) chk("go_without_job", 1, 0);
          else begin
            chk("go_job_nontrivial", 32'(exp_q[0].b < exp_q[0].e), 1);
            exp_count--;
          end
        end
        if (res_valid && !prev_rv && !prev_go) begin
          if (exp_q.size() == 0) chk("result_without_job", 1, 0);
          else begin
            chk("local_job_trivial", 32'(exp_q[0].b >= exp_q[0].e), 1);
            exp_count--;
          end
        end
        if (chk_go) begin
          go_cycles++;
          if (exp_q.size() > 0) begin
            chk("chk_base", chk_base, exp_q[0].b);
            chk("chk_ending", chk_ending, exp_q[0].e);
          end
        end
        chk("job_count", job_count, exp_count);
        chk("req_ready", req_ready, 32'(exp_count < DEPTH));
        if (res_valid) begin
          chk("go_low_in_report", chk_go, 0);
          if (exp_q.size() == 0) chk("res_unexpected", 1, 0);
          else begin
            triv = (exp_q[0].b >= exp_q[0].e);
            chk("res_base", res_base, exp_q[0].b);
            chk("res_ending", res_ending, exp_q[0].e);
            if (triv) begin
              chk("res_palindrome_local", res_palindrome, 1);
              chk("res_timeout_local", res_timeout, 0);
            end else begin
              chk("res_palindrome", res_palindrome, (plan_d <= TIMEOUT) ? plan_pal : 1'b0);
              chk("res_timeout", res_timeout, 32'(plan_d > TIMEOUT));
              if (!prev_rv) begin
                exp_gc = (plan_d < TIMEOUT) ? plan_d : TIMEOUT;
                chk("go_cycles", go_cycles, exp_gc);
              end
            end
            if (res_ready) begin
              void'(exp_q.pop_front());
              results_seen++;
            end
          end
        end
        if (req_valid && req_ready) begin
          exp_q.push_back('{req_base, req_ending});
          exp_count++;
        end
        prev_go = chk_go;
        prev_rv = res_valid;
      end
    end
  end

  task automatic push(input logic [4:0] b, input logic [4:0] e);
    bit ok;
    req_valid = 1'b1; req_base = b; req_ending = e;
    for (int n = 0; n < 500; n++) begin
      ok = req_ready;
      @(posedge clock); #1;
      if (ok) break;
      if (n == 499) chk("push_accept_timeout", 0, 1);
    end
    req_valid = 1'b0;
  endtask

  task automatic wait_res(input int max);
    for (int n = 0; n < max && !res_valid; n++) begin
      @(posedge clock); #1;
    end
    chk("wait_res_bound", res_valid, 1);
  endtask

  task automatic consume();
    res_ready = 1'b1;
    @(posedge clock); #1;
    res_ready = 1'b0;
  endtask

  task automatic drain(input int max);
    res_ready = 1'b1;
    for (int n = 0; n < max && exp_q.size() != 0; n++) begin
      @(posedge clock); #1;
    end
    @(posedge clock); #1;
    res_ready = 1'b0;
    chk("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    int   r0, s0;
    logic exp_pal [4];
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   r0, s0;
    logic exp_pal [4];
    repeat (3) @(posedge clock);
    #1;
    chk("rst_chk_go", chk_go, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_job_count", job_count, 0);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_chk_base", chk_base, 0);
    chk("rst_res_base", res_base, 0);
    reset = 1'b1;
    @(posedge clock); #1;

    // Basic job: go two edges after push, held five cycles.
    force_q.push_back('{5, 1'b1});
    push(5'd11, 5'd14);
    chk("lat_go_early", chk_go, 0);
    @(posedge clock); #1;
    chk("lat_go", chk_go, 1);
    chk("t1_chk_base", chk_base, 11);
    wait_res(100);
    chk("t1_pal", res_palindrome, 1);
    chk("t1_to", res_timeout, 0);
    chk("t1_base", res_base, 11);
    chk("t1_ending", res_ending, 14);
    chk("t1_go_cycles", go_cycles, 5);
    consume();

    // Trivial job latency: answer two edges after push.
    push(5'd9, 5'd9);
    chk("lat_triv_early", res_valid, 0);
    @(posedge clock); #1;
    chk("lat_triv", res_valid, 1);
    consume();

    // Back-to-back jobs, two checker jobs and two trivial ones.
    force_q.push_back('{3, 1'b1});
    force_q.push_back('{4, 1'b0});
    r0 = go_rises;
    push(5'd2, 5'd6); push(5'd7, 5'd11); push(5'd3, 5'd3); push(5'd9, 5'd4);
    exp_pal[0] = 1'b1; exp_pal[1] = 1'b0; exp_pal[2] = 1'b1; exp_pal[3] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_res(100);
      chk("t2_pal", res_palindrome, exp_pal[i]);
      consume();
    end
    chk("t2_go_pulses", go_rises - r0, 2);

    // Fill the FIFO behind a stalled result.
    force_q.push_back('{2, 1'b1});
    push(5'd1, 5'd9);
    push(5'd1, 5'd2); push(5'd3, 5'd8); push(5'd5, 5'd5); push(5'd6, 5'd10);
    chk("t3_full_count", job_count, 4);
    chk("t3_full_ready", req_ready, 0);
    req_valid = 1'b1; req_base = 5'd7; req_ending = 5'd7;
    repeat (5) @(posedge clock);
    #1;
    req_valid = 1'b0;
    s0 = results_seen;
    drain(2000);
    chk("t3_results", results_seen - s0, 5);

    // Timeout, then stray dones while reporting, then a normal job.
    inject_en = 1'b1;
    force_q.push_back('{TIMEOUT + 10, 1'b1});
    push(5'd2, 5'd5);
    wait_res(200);
    chk("t4_to", res_timeout, 1);
    chk("t4_pal", res_palindrome, 0);
    chk("t4_go_cycles", go_cycles, TIMEOUT);
    repeat (4) @(posedge clock);
    #1;
    chk("t4_hold_to", res_timeout, 1);
    consume();
    force_q.push_back('{3, 1'b1});
    push(5'd4, 5'd8);
    wait_res(100);
    chk("t4_next_pal", res_palindrome, 1);
    chk("t4_next_to", res_timeout, 0);
    consume();
    inject_en = 1'b0;

    // Reset in the middle of a run with two jobs queued.
    force_q.push_back('{TIMEOUT + 10, 1'b0});
    push(5'd2, 5'd5); push(5'd1, 5'd3); push(5'd4, 5'd9);
    @(posedge clock); #3;
    reset = 1'b0;
    #1;
    chk("t5_go", chk_go, 0);
    chk("t5_res_valid", res_valid, 0);
    chk("t5_count", job_count, 0);
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    repeat (10) @(posedge clock);
    #1;
    chk("t5_no_stale", res_valid, 0);
    force_q.push_back('{4, 1'b1});
    push(5'd2, 5'd5);
    wait_res(100);
    chk("t5_pal", res_palindrome, 1);
    chk("t5_base", res_base, 2);
    consume();

    // Push and pop in the same cycle with two jobs queued.
    force_q.push_back('{1, 1'b1});
    push(5'd1, 5'd2); push(5'd3, 5'd3); push(5'd4, 5'd4);
    wait_res(100);
    chk("t6_count_pre", job_count, 2);
    consume();
    req_valid = 1'b1; req_base = 5'd8; req_ending = 5'd9;
    @(posedge clock); #1;
    req_valid = 1'b0;
    chk("t6_count_same", job_count, 2);
    drain(1000);

    // done in the very cycle the timer expires.
    force_q.push_back('{TIMEOUT, 1'b1});
    push(5'd2, 5'd5);
    wait_res(200);
    chk("t6_edge_pal", res_palindrome, 1);
    chk("t6_edge_to", res_timeout, 0);
    chk("t6_edge_go_cycles", go_cycles, TIMEOUT);
    consume();

    // Random traffic against the reference model.
    inject_en = 1'b1;
    for (int c = 0; c < 600; c++) begin
      req_valid  = ($urandom_range(0, 2) != 0);
      req_base   = 5'($urandom_range(0, 31));
      req_ending = 5'($urandom_range(0, 31));
      res_ready  = ($urandom_range(0, 3) != 0);
      @(posedge clock); #1;
    end
    req_valid = 1'b0;
    drain(5000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
